// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the pipeline debug controller:
//   - FSM state encoding
//   - default command byte values (ASCII 'c', 's', 'd', 'p')
//   - dump framing constants
// -----------------------------------------------------------------------------
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_WAIT = 3'd5
  } state_e;

  localparam logic [7:0] DEF_CMD_RUN   = 8'h63;
  localparam logic [7:0] DEF_CMD_STEP  = 8'h73;
  localparam logic [7:0] DEF_CMD_DUMP  = 8'h64;
  localparam logic [7:0] DEF_CMD_PAUSE = 8'h70;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

endpackage

// File: rtl/debug_ctrl_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Produces a single-clock pulse on the rising edge of a level input by
// comparing it with a registered copy. A level held high yields one pulse.
//
// Ports:
//   clock  in   board clock
//   reset  in   asynchronous, active-high; registered copy clears to 0
//   level  in   level-type flag to watch
//   pulse  out  high for the clock where level is 1 and its copy is 0
// -----------------------------------------------------------------------------
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/debug_ctrl.sv
// -----------------------------------------------------------------------------
// debug_ctrl
// Pipeline debug session sequencer. Single-byte commands arriving from the
// UART receiver run, single-step or pause the pipeline clock-enable. After
// every stop a dump of DUMP_WORDS 32-bit words is streamed little-endian
// through the UART transmitter, one byte per tx handshake.
//
// Optional build macro: DEBUG_CYCLE_COUNT_EN
//   When defined, a 32-bit counter of pipe_enable clocks (wrapping, cleared
//   only by reset) is appended to each dump as four extra little-endian bytes.
//
// Ports:
//   clock        in   board clock
//   reset        in   asynchronous, active-high
//   rx_done      in   receiver done flag (level)
//   rx_data[7:0] in   received byte, valid while rx_done is high
//   tx_done      in   transmitter byte-complete flag (level)
//   tx_start     out  one-clock request to send tx_data
//   tx_data[7:0] out  byte to send, stable until the tx_done rising edge
//   halt         in   pipeline reached a halt instruction
//   pipe_enable  out  pipeline clock-enable
//   dump_addr    out  dump word select
//   dump_data    in   combinational word at dump_addr
//   busy         out  high whenever the FSM is not idle
//
// State table:
//   ST_IDLE | waiting for a command byte
//   ST_RUN  | pipeline running until halt or pause
//   ST_STEP | pipeline enabled for a single clock
//   ST_LOAD | capture dump word (or cycle count) into the shift register
//   ST_SEND | pulse tx_start with the low byte of the shift register
//   ST_WAIT | wait for tx_done rising edge, then advance byte/word
// -----------------------------------------------------------------------------
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int         DUMP_WORDS = 32,
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] CMD_RUN    = DEF_CMD_RUN,
  parameter logic [7:0] CMD_STEP   = DEF_CMD_STEP,
  parameter logic [7:0] CMD_DUMP   = DEF_CMD_DUMP,
  parameter logic [7:0] CMD_PAUSE  = DEF_CMD_PAUSE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              halt,
  output logic              pipe_enable,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [31:0]       dump_data,
  output logic              busy
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [31:0]             shift_q, shift_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

  logic rx_evt;
  logic tx_evt;
  logic cmd_run, cmd_step, cmd_dump, cmd_pause;
  logic last_byte;
  logic last_word;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  // Set once the data words are done and the trailing count word is in flight.
  logic        tail_q, tail_d;
`endif

  edge_detect u_rx_edge (
    .clock (clock),
    .reset (reset),
    .level (rx_done),
    .pulse (rx_evt)
  );

  edge_detect u_tx_edge (
    .clock (clock),
    .reset (reset),
    .level (tx_done),
    .pulse (tx_evt)
  );

  assign cmd_run   = rx_evt && (rx_data == CMD_RUN);
  assign cmd_step  = rx_evt && (rx_data == CMD_STEP);
  assign cmd_dump  = rx_evt && (rx_data == CMD_DUMP);
  assign cmd_pause = rx_evt && (rx_data == CMD_PAUSE);

  assign last_byte = (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign last_word = (addr_q == ADDR_W'(DUMP_WORDS - 1));

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
`ifdef DEBUG_CYCLE_COUNT_EN
      cyc_cnt_q  <= '0;
      tail_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef DEBUG_CYCLE_COUNT_EN
      cyc_cnt_q  <= cyc_cnt_d;
      tail_q     <= tail_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
`ifdef DEBUG_CYCLE_COUNT_EN
    tail_d     = tail_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A halted pipeline cannot run; go straight to the dump.
        if (cmd_run) begin
          state_d = halt ? ST_LOAD : ST_RUN;
        end else if (cmd_step) begin
          state_d = halt ? ST_LOAD : ST_STEP;
        end else if (cmd_dump) begin
          state_d = ST_LOAD;
        end
      end

      ST_RUN: begin
        // halt has priority over a pause arriving in the same clock
        if (halt) begin
          state_d = ST_LOAD;
        end else if (cmd_pause) begin
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
`ifdef DEBUG_CYCLE_COUNT_EN
        shift_d = tail_q ? cyc_cnt_q : dump_data;
`else
        shift_d = dump_data;
`endif
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (tx_evt) begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          if (!last_byte) begin
            state_d = ST_SEND;
          end else if (!last_word) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_LOAD;
          end else begin
`ifdef DEBUG_CYCLE_COUNT_EN
            // dump_addr parks on the last word while the count is sent.
            if (!tail_q) begin
              tail_d  = 1'b1;
              state_d = ST_LOAD;
            end else begin
              tail_d  = 1'b0;
              addr_d  = '0;
              state_d = ST_IDLE;
            end
`else
            addr_d  = '0;
            state_d = ST_IDLE;
`endif
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    pipe_enable = 1'b0;
    tx_start    = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_IDLE: busy        = 1'b0;
      ST_RUN:  pipe_enable = 1'b1;
      ST_STEP: pipe_enable = 1'b1;
      ST_SEND: tx_start    = 1'b1;
      default: ;
    endcase
  end

  // The shift register drains to zero after the last byte, so tx_data
  // idles at 0 between dumps.
  assign tx_data   = shift_q[7:0];
  assign dump_addr = addr_q;

`ifdef DEBUG_CYCLE_COUNT_EN
  always_comb begin
    cyc_cnt_d = cyc_cnt_q + (pipe_enable ? 32'd1 : 32'd0);
  end
`endif

endmodule

// File: tb/tb_debug_ctrl.sv
module tb_debug_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int DUMP_LEN = 4 * DW + 4;
`else
  localparam int DUMP_LEN = 4 * DW;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          tx_done;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          halt;
  logic          pipe_enable;
  logic [AW-1:0] dump_addr;
  logic [31:0]   dump_data;
  logic          busy;

  logic [31:0] mem [0:DW-1];
  assign dump_data = mem[dump_addr];

  debug_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .halt        (halt),
    .pipe_enable (pipe_enable),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pe_cnt = 0;
  int pe_total = 0;
  logic [7:0] tx_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Transmitter stand-in: logs each requested byte, answers with a
  // tx_done level held 1..3 clocks after a 4..7 clock delay.
  int tx_dly = 0;
  int tx_hold = 0;
  always @(negedge clock) begin
    if (pipe_enable) begin
      pe_cnt++;
      pe_total++;
    end
    if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) tx_done = 1'b0;
    end
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_dly = $urandom_range(4, 7);
    end else if (tx_dly > 0) begin
      tx_dly--;
      if (tx_dly == 0) begin
        tx_done = 1'b1;
        tx_hold = $urandom_range(1, 3);
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    if (i / 4 < DW) w = mem[i / 4];
    else            w = pe_total;
    return 8'(w >> (8 * (i % 4)));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, output int t);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    t = cyc;
    repeat (hold) @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) @(negedge clock);
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_dump(input string tag);
    chk({tag, "_len"}, tx_log.size(), DUMP_LEN);
    for (int i = 0; i < DUMP_LEN; i++)
      chk($sformatf("%s_b%0d", tag, i), (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_byte(i));
    tx_log.delete();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DW; i++) mem[i] = $urandom;
  endtask

  task automatic start_test();
    fill_mem();
    pe_cnt = 0;
    tx_log.delete();
  endtask

  initial begin
    int t0, t1, kind, r, endk;
    logic [7:0] other;

    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0; halt = 1'b0;
    fill_mem();
    repeat (3) @(negedge clock);
    chk("rst_pe", pipe_enable, 1'b0);
    chk("rst_txs", tx_start, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_addr", dump_addr, '0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    pe_total = 0;
    repeat (3) @(negedge clock);

    // Single step
    start_test();
    mem[0] = 32'h0403_0201;
    send_byte(8'h73, 1, t0);
    wait_idle("step");
    chk("step_pe", pe_cnt, 1);
    chk("step_first0", tx_log[0], 8'h01);
    chk("step_first1", tx_log[1], 8'h02);
    chk("step_first2", tx_log[2], 8'h03);
    chk("step_first3", tx_log[3], 8'h04);
    check_dump("step");
    chk("step_addr0", dump_addr, '0);

    // Run then pause
    start_test();
    send_byte(8'h63, 1, t0);
    repeat (50) @(negedge clock);
    send_byte(8'h70, 1, t1);
    repeat (10) @(negedge clock);
    chk("pause_pe", pe_cnt, t1 - t0);
    chk("pause_ntx", tx_log.size(), 0);
    chk("pause_busy", busy, 1'b0);

    // Run, then halt and pause in the same clock: halt wins
    start_test();
    send_byte(8'h63, 1, t0);
    repeat (10) @(negedge clock);
    @(negedge clock);
    t1 = cyc; halt = 1'b1; rx_data = 8'h70; rx_done = 1'b1;
    @(negedge clock);
    halt = 1'b0; rx_done = 1'b0;
    chk("hp_pe_off", pipe_enable, 1'b0);
    chk("hp_busy", busy, 1'b1);
    wait_idle("hp");
    chk("hp_pe", pe_cnt, t1 - t0);
    check_dump("hp");

    // Dump command held high for 1000 clocks -> one dump only
    start_test();
    send_byte(8'h64, 1000, t0);
    wait_idle("hold");
    repeat (30) @(negedge clock);
    chk("hold_busy", busy, 1'b0);
    chk("hold_pe", pe_cnt, 0);
    check_dump("hold");

    // Bytes during a dump are dropped
    start_test();
    send_byte(8'h64, 2, t0);
    repeat (40) @(negedge clock);
    send_byte(8'h63, 2, t1);
    repeat (5) @(negedge clock);
    send_byte(8'h64, 2, t1);
    wait_idle("drop");
    repeat (30) @(negedge clock);
    chk("drop_busy", busy, 1'b0);
    chk("drop_pe", pe_cnt, 0);
    check_dump("drop");

    // Reset during WAIT of word 5 byte 2
    start_test();
    send_byte(8'h64, 1, t0);
    r = 0;
    while (tx_log.size() < 23 && r < 3000) begin
      @(negedge clock);
      r++;
    end
    chk("mid_reach", tx_log.size(), 23);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_pe", pipe_enable, 1'b0);
    chk("mid_txs", tx_start, 1'b0);
    chk("mid_txd", tx_data, 8'h00);
    chk("mid_addr", dump_addr, '0);
    chk("mid_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    pe_total = 0;
    repeat (20) @(negedge clock);
    start_test();
    send_byte(8'h64, 1, t0);
    wait_idle("restart");
    check_dump("restart");

    // Three steps; cycle count (when built) reads 3 on the third dump
    for (int k = 0; k < 3; k++) begin
      start_test();
      send_byte(8'h73, 1, t0);
      wait_idle("s3");
      chk("s3_pe", pe_cnt, 1);
`ifdef DEBUG_CYCLE_COUNT_EN
      if (k == 2) begin
        chk("s3_cnt0", tx_log[4 * DW], 8'h03);
        chk("s3_cnt1", tx_log[4 * DW + 1], 8'h00);
        chk("s3_cnt2", tx_log[4 * DW + 2], 8'h00);
        chk("s3_cnt3", tx_log[4 * DW + 3], 8'h00);
      end
`endif
      check_dump("s3");
    end

    // Randomized command sessions
    for (int it = 0; it < 8; it++) begin
      logic dump_exp;
      int pe_exp;
      start_test();
      kind = $urandom_range(0, 5);
      dump_exp = 1'b1;
      pe_exp = 0;
      case (kind)
        0: begin send_byte(8'h73, 1, t0); pe_exp = 1; end
        1: begin halt = 1'b1; send_byte(8'h73, 1, t0); halt = 1'b0; end
        2: begin halt = 1'b1; send_byte(8'h63, 2, t0); halt = 1'b0; end
        3: begin
          send_byte(8'h63, $urandom_range(1, 3), t0);
          r = $urandom_range(5, 60);
          repeat (r) @(negedge clock);
          endk = $urandom_range(0, 2);
          @(negedge clock);
          t1 = cyc;
          if (endk != 1) begin rx_data = 8'h70; rx_done = 1'b1; end
          if (endk != 0) halt = 1'b1;
          @(negedge clock);
          rx_done = 1'b0; halt = 1'b0;
          pe_exp = t1 - t0;
          dump_exp = (endk != 0);
        end
        4: send_byte(8'h64, $urandom_range(1, 20), t0);
        default: begin
          other = 8'($urandom);
          while (other == 8'h63 || other == 8'h73 || other == 8'h64) other = 8'($urandom);
          send_byte(other, 1, t0);
          dump_exp = 1'b0;
        end
      endcase
      if (dump_exp) begin
        wait_idle("rnd");
        chk("rnd_pe", pe_cnt, pe_exp);
        check_dump("rnd");
      end else begin
        repeat (10) @(negedge clock);
        chk("rnd_nodump_busy", busy, 1'b0);
        chk("rnd_nodump_ntx", tx_log.size(), 0);
        chk("rnd_nodump_pe", pe_cnt, pe_exp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
